// File: rtl/decryption_dispatcher.sv
// rtl/decryption_dispatcher.sv - message framing and engine dispatch front-end for the decryption engine bank
//
// Frames each incoming message, latches the engine select on the first
// character, forwards characters to the chosen engine (0=caesar, 1=scytale,
// 2=zigzag), stalls upstream while the engine works and merges the engine
// outputs back into one stream.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   data_i/valid_i/sel_i   incoming character, qualifier, engine select
//   ready_o                dispatcher accepts data_i
//   eng_data_o/eng_valid_o per-engine forwarded character and one-hot valid
//   eng_busy_i             per-engine busy
//   eng_data_i/eng_valid_i per-engine decrypted character and valid
//   data_o/valid_o         merged decrypted character and qualifier
//   busy_o                 message in progress
//   err_o                  1-cycle pulse: invalid select, overflow or busy timeout
//
// Optional feature macro DISPATCHER_STATS_EN adds msg_cnt_o[15:0] and
// err_cnt_o[7:0] saturating statistics counters.

module decryption_dispatcher #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 BUSY_WAIT_MAX          = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [1:0]           sel_i,
  output logic                 ready_o,
  output logic [3*D_WIDTH-1:0] eng_data_o,
  output logic [2:0]           eng_valid_o,
  input  logic [2:0]           eng_busy_i,
  input  logic [3*D_WIDTH-1:0] eng_data_i,
  input  logic [2:0]           eng_valid_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 err_o
`ifdef DISPATCHER_STATS_EN
  ,
  output logic [15:0]          msg_cnt_o,
  output logic [7:0]           err_cnt_o
`endif
);

  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int WW = $clog2(BUSY_WAIT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_WAIT_RISE, S_WAIT_FALL} state_t;

  state_t               state;
  logic [1:0]           sel_q;
  logic [CW-1:0]        char_cnt;
  logic                 ovf_seen;
  logic [WW-1:0]        wait_cnt;

  logic                 accept;
  logic                 is_token;
  logic                 room;
  logic [1:0]           fwd_sel;
  logic [2:0]           fwd_mask;
  logic                 sel_busy;
  logic                 sel_valid;
  logic [D_WIDTH-1:0]   sel_data;

  assign accept   = valid_i & ready_o;
  assign is_token = (data_i == START_DECRYPTION_TOKEN);
  assign room     = (char_cnt < CW'(MAX_NOF_CHARS));

  // In IDLE the select comes straight from the input; afterwards the latched one.
  // The token is always forwarded, ordinary chars only while there is room.
  always_comb begin
    fwd_sel  = (state == S_IDLE) ? sel_i : sel_q;
    fwd_mask = 3'b000;
    if (accept && (fwd_sel != 2'd3) && ((state == S_IDLE) || is_token || room))
      fwd_mask = 3'b001 << fwd_sel;
  end

  // Return-path mux for the latched engine; select 3 selects nothing.
  always_comb begin
    sel_busy  = 1'b0;
    sel_valid = 1'b0;
    sel_data  = '0;
    case (sel_q)
      2'd0: begin
        sel_busy  = eng_busy_i[0];
        sel_valid = eng_valid_i[0];
        sel_data  = eng_data_i[0 +: D_WIDTH];
      end
      2'd1: begin
        sel_busy  = eng_busy_i[1];
        sel_valid = eng_valid_i[1];
        sel_data  = eng_data_i[D_WIDTH +: D_WIDTH];
      end
      2'd2: begin
        sel_busy  = eng_busy_i[2];
        sel_valid = eng_valid_i[2];
        sel_data  = eng_data_i[2*D_WIDTH +: D_WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel_q       <= 2'd0;
      char_cnt    <= '0;
      ovf_seen    <= 1'b0;
      wait_cnt    <= '0;
      ready_o     <= 1'b1;
      eng_data_o  <= '0;
      eng_valid_o <= 3'b000;
      data_o      <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      eng_valid_o <= fwd_mask;
      err_o       <= 1'b0;
      for (int n = 0; n < 3; n++) begin
        if (fwd_mask[n]) eng_data_o[n*D_WIDTH +: D_WIDTH] <= data_i;
      end

      // Merge is live in both wait states, which includes the exit cycle.
      valid_o <= 1'b0;
      if ((state == S_WAIT_RISE) || (state == S_WAIT_FALL)) begin
        valid_o <= sel_valid;
        if (sel_valid) data_o <= sel_data;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            sel_q    <= sel_i;
            ovf_seen <= 1'b0;
            char_cnt <= '0;
            if (sel_i == 2'd3) begin
              err_o  <= 1'b1;
              busy_o <= !is_token;
              if (!is_token) state <= S_FWD;
            end else begin
              busy_o <= 1'b1;
              if (is_token) begin
                ready_o  <= 1'b0;
                wait_cnt <= '0;
                state    <= S_WAIT_RISE;
              end else begin
                char_cnt <= CW'(1);
                state    <= S_FWD;
              end
            end
          end
        end
        S_FWD: begin
          if (accept) begin
            if (is_token) begin
              if (sel_q == 2'd3) begin
                busy_o <= 1'b0;
                state  <= S_IDLE;
              end else begin
                ready_o  <= 1'b0;
                wait_cnt <= '0;
                state    <= S_WAIT_RISE;
              end
            end else if (sel_q != 2'd3) begin
              if (room) begin
                char_cnt <= char_cnt + 1'b1;
              end else if (!ovf_seen) begin
                ovf_seen <= 1'b1;
                err_o    <= 1'b1;
              end
            end
          end
        end
        S_WAIT_RISE: begin
          if (sel_busy) begin
            state <= S_WAIT_FALL;
          end else if (wait_cnt == WW'(BUSY_WAIT_MAX - 1)) begin
            err_o   <= 1'b1;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (!sel_busy) begin
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DISPATCHER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if ((state == S_WAIT_FALL) && !sel_busy && (msg_cnt_o != 16'hFFFF))
        msg_cnt_o <= msg_cnt_o + 1'b1;
      if (err_o && (err_cnt_o != 8'hFF))
        err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decryption_dispatcher.sv
// tb/tb_decryption_dispatcher.sv - randomized self-checking bench for decryption_dispatcher

module tb_decryption_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [1:0]  sel_i;
  logic        ready_o;
  logic [23:0] eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [2:0]  eng_busy_i;
  logic [23:0] eng_data_i;
  logic [2:0]  eng_valid_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        busy_o;
  logic        err_o;
`ifdef DISPATCHER_STATS_EN
  logic [15:0] msg_cnt_o;
  logic [7:0]  err_cnt_o;
`endif

  decryption_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
    .ready_o(ready_o), .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
    .eng_busy_i(eng_busy_i), .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o)
`ifdef DISPATCHER_STATS_EN
    , .msg_cnt_o(msg_cnt_o), .err_cnt_o(err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  localparam int MAXC = 50;
  localparam int WAITMAX = 4;

  int tests = 0;
  int fails = 0;
  int m_msgs = 0;
  int m_errs = 0;

  // Expected values for the next sampled cycle.
  logic       x_ready, x_busy, x_err, x_valid_o;
  logic [2:0] x_eng_valid;
  logic [7:0] x_eng_dat, x_data_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle_chk();
    @(negedge clk);
    check("ready", ready_o, x_ready);
    check("busy", busy_o, x_busy);
    check("err", err_o, x_err);
    check("eng_valid", eng_valid_o, x_eng_valid);
    for (int n = 0; n < 3; n++)
      if (x_eng_valid[n]) check("eng_data", eng_data_o[n*8 +: 8], x_eng_dat);
    check("valid_o", valid_o, x_valid_o);
    check("data_o", data_o, x_data_o);
    if (x_err) m_errs++;
    x_err = 1'b0;
    x_eng_valid = 3'b000;
    x_valid_o = 1'b0;
  endtask

  // Engine s behaves as a real engine (busy as given, output only while busy);
  // every other engine gets random noise that must be ignored.
  task automatic drive_engines(input int s, input bit b);
    logic [7:0] d;
    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom);
      eng_data_i[n*8 +: 8] = d;
      if (n == s) begin
        eng_busy_i[n]  = b;
        eng_valid_i[n] = b & 1'($urandom_range(0, 1));
        if (eng_valid_i[n]) begin
          x_valid_o = 1'b1;
          x_data_o  = d;
        end
      end else begin
        eng_busy_i[n]  = 1'($urandom_range(0, 1));
        eng_valid_i[n] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // One message: nchars ordinary chars then the token. Engine busy is high
  // for cycles rise..rise+len-1 counted from the cycle the token is forwarded.
  task automatic run_msg(input int sel, input int nchars, input int rise, input int len,
                         input bit never, input bit gaps, input bit fixed, input int abort_at);
    bit   started = 0;
    bit   dropped = 0;
    int   cnt = 0;
    bit   tok;
    bit   b;
    logic [7:0] c;
    for (int i = 0; i <= nchars; i++) begin
      if (i == abort_at) begin
        valid_i = 1'b0;
        return;
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          valid_i = 1'b0;
          data_i  = 8'($urandom);
          sel_i   = 2'($urandom);
          drive_engines(sel, 1'b0);
          cycle_chk();
        end
      end
      tok = (i == nchars);
      if (tok) c = 8'hFA;
      else if (fixed) c = 8'h41 + 8'(i);
      else begin
        c = 8'($urandom);
        if (c == 8'hFA) c = 8'h3C;
      end
      valid_i = 1'b1;
      data_i  = c;
      sel_i   = started ? 2'($urandom) : 2'(sel);
      drive_engines(sel, 1'b0);
      if (!started) begin
        started = 1;
        x_busy  = 1'b1;
        if (sel == 3) x_err = 1'b1;
      end
      if (sel == 3) begin
        if (tok) x_busy = 1'b0;
      end else if (tok) begin
        x_eng_valid = 3'b001 << sel;
        x_eng_dat   = c;
        x_ready     = 1'b0;
      end else if (cnt < MAXC) begin
        cnt++;
        x_eng_valid = 3'b001 << sel;
        x_eng_dat   = c;
      end else if (!dropped) begin
        dropped = 1;
        x_err   = 1'b1;
      end
      cycle_chk();
    end
    if (sel != 3) begin
      for (int k = 0; k < 64; k++) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = 8'($urandom);
        sel_i   = 2'($urandom);
        b = !never && (k >= rise) && (k < rise + len);
        drive_engines(sel, b);
        if (never && k == WAITMAX - 1) begin
          x_err = 1'b1; x_ready = 1'b1; x_busy = 1'b0;
          cycle_chk();
          break;
        end
        if (!never && k == rise + len) begin
          x_ready = 1'b1; x_busy = 1'b0;
          m_msgs++;
          cycle_chk();
          break;
        end
        cycle_chk();
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic idle_cycle();
    valid_i = 1'b0;
    drive_engines(3, 1'b0);
    cycle_chk();
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; data_i = '0; sel_i = '0;
    eng_busy_i = '0; eng_valid_i = '0; eng_data_i = '0;
    x_ready = 1'b1; x_busy = 1'b0; x_err = 1'b0; x_eng_valid = '0;
    x_eng_dat = '0; x_valid_o = 1'b0; x_data_o = '0;
    cycle_chk();
    cycle_chk();
    rst_n = 1'b1;

    run_msg(1, 6, 1, 6, 1'b0, 1'b0, 1'b1, -1);
    run_msg(3, 2, 1, 1, 1'b0, 1'b0, 1'b0, -1);
    run_msg(0, 52, 2, 3, 1'b0, 1'b0, 1'b0, -1);
    run_msg(2, 0, 1, 1, 1'b1, 1'b0, 1'b0, -1);
    idle_cycle();
`ifdef DISPATCHER_STATS_EN
    check("msg_cnt", msg_cnt_o, 32'(m_msgs));
    check("err_cnt", err_cnt_o, 32'(m_errs));
`endif

    run_msg(0, 10, 1, 1, 1'b0, 1'b0, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_eng_valid", eng_valid_o, 0);
    check("rst_eng_data", eng_data_o, 0);
    check("rst_valid_o", valid_o, 0);
    check("rst_data_o", data_o, 0);
`ifdef DISPATCHER_STATS_EN
    check("rst_msg_cnt", msg_cnt_o, 0);
    check("rst_err_cnt", err_cnt_o, 0);
`endif
    m_msgs = 0; m_errs = 0;
    x_ready = 1'b1; x_busy = 1'b0; x_data_o = '0;
    cycle_chk();
    rst_n = 1'b1;
    run_msg(0, 5, 1, 2, 1'b0, 1'b0, 1'b0, -1);

    for (int m = 0; m < 25; m++) begin
      int s;
      s = $urandom_range(0, 3);
      run_msg(s, $urandom_range(0, 55), $urandom_range(1, 3), $urandom_range(1, 5),
              ($urandom_range(0, 4) == 0), 1'b1, 1'b0, -1);
    end
    idle_cycle();
`ifdef DISPATCHER_STATS_EN
    check("end_msg_cnt", msg_cnt_o, 32'(m_msgs));
    check("end_err_cnt", err_cnt_o, 32'(m_errs));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
